// File: rtl/cdc_bus_sync.sv
// cdc_bus_sync: destination-domain synchroniser for a multi-bit bus that is
// qualified by a single enable line from another clock domain. Only the
// enable crosses through a flip-flop chain. A registered edge detector then
// captures the bus, which the source holds stable, and issues a one-cycle
// strobe. A wrapping transfer counter is kept for debug.
//
// Parameters:
//   NUM_STAGES  enable synchroniser depth (2..8)
//   BUS_WIDTH   width of the synchronised bus
//   ENABLE_MODE 0 = rising edge of bus_enable is a transfer, 1 = any change
//   CNT_WIDTH   width of the transfer counter
// Ports:
//   clk           destination-domain clock
//   rst           asynchronous active-low reset
//   unsync_bus    source-domain data, stable while a transfer is pending
//   bus_enable    source-domain transfer qualifier, unsynchronised
//   sync_bus      captured data, holds between transfers (registered)
//   enable_pulse  one-cycle strobe in the cycle sync_bus takes new data (registered)
//   xfer_count    transfers captured since reset, wraps (registered)
module cdc_bus_sync #(
   parameter int unsigned NUM_STAGES  = 2,
   parameter int unsigned BUS_WIDTH   = 8,
   parameter int unsigned ENABLE_MODE = 0,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] unsync_bus,
   input  logic                 bus_enable,
   output logic [BUS_WIDTH-1:0] sync_bus,
   output logic                 enable_pulse,
   output logic [CNT_WIDTH-1:0] xfer_count
);

   // Reject illegal configurations at elaboration.
   if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_stages
      $error("cdc_bus_sync: NUM_STAGES must be in 2..8");
   end
   if (ENABLE_MODE > 1) begin : g_bad_mode
      $error("cdc_bus_sync: ENABLE_MODE must be 0 or 1");
   end

   logic [NUM_STAGES-1:0] sync_q, sync_d;
   logic                  en_prev_q, en_prev_d;
   logic [BUS_WIDTH-1:0]  bus_q, bus_d;
   logic                  pulse_q, pulse_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  en_s_c;
   logic                  edge_c;

   // Next-state: shift the enable through the chain, detect the event, capture.
   always_comb begin
      sync_d    = {sync_q[NUM_STAGES-2:0], bus_enable};
      en_s_c    = sync_q[NUM_STAGES-1];
      en_prev_d = en_s_c;
      bus_d     = bus_q;
      cnt_d     = cnt_q;
      pulse_d   = 1'b0;
      if (ENABLE_MODE == 1) begin
         edge_c = en_s_c ^ en_prev_q;
      end else begin
         edge_c = en_s_c & ~en_prev_q;
      end
      if (edge_c) begin
         bus_d   = unsync_bus;
         pulse_d = 1'b1;
         cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
   end

   // State registers; reset discards any transfer still in the chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q    <= '0;
         en_prev_q <= 1'b0;
         bus_q     <= '0;
         pulse_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync_q    <= sync_d;
         en_prev_q <= en_prev_d;
         bus_q     <= bus_d;
         pulse_q   <= pulse_d;
         cnt_q     <= cnt_d;
      end
   end

   assign sync_bus     = bus_q;
   assign enable_pulse = pulse_q;
   assign xfer_count   = cnt_q;

endmodule

// File: tb/tb_cdc_bus_sync.sv
// tb_cdc_bus_sync: drives seven cdc_bus_sync configurations from one clock.
// A delay-line model predicts every output on every edge: the registered
// outputs at edge n reflect the enable event between the samples taken at
// edges n-N-1 and n-N, with samples at or before the latest reset edge read
// as 0. Directed sequences add literal expectations; random sequences on the
// last three instances feed a data scoreboard.
module tb_cdc_bus_sync;

   localparam int NI   = 7;
   localparam int MAXC = 8192;

   function automatic int ns_of(input int i);
      case (i)
         0: return 2; 1: return 4; 2: return 3; 3: return 2;
         4: return 2; 5: return 5; default: return 8;
      endcase
   endfunction
   function automatic int bw_of(input int i);
      case (i)
         4: return 1; 5: return 32; 6: return 32; default: return 8;
      endcase
   endfunction
   function automatic int em_of(input int i);
      return (i == 2 || i == 4 || i == 6) ? 1 : 0;
   endfunction
   function automatic int cw_of(input int i);
      case (i)
         3: return 2; 5: return 4; default: return 8;
      endcase
   endfunction
   function automatic logic [31:0] mask_of(input int i);
      logic [32:0] one;
      one = 33'd1 << bw_of(i);
      return 32'(one - 33'd1);
   endfunction

   logic        clk;
   logic        rst;
   logic        en      [NI];
   logic [31:0] bus_in  [NI];
   logic [31:0] sync_o  [NI];
   logic        pulse_o [NI];
   logic [7:0]  cnt_o   [NI];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned N  = ns_of(g);
      localparam int unsigned BW = bw_of(g);
      localparam int unsigned EM = em_of(g);
      localparam int unsigned CW = cw_of(g);
      logic [BW-1:0] so;
      logic [CW-1:0] co;
      cdc_bus_sync #(
         .NUM_STAGES (N),
         .BUS_WIDTH  (BW),
         .ENABLE_MODE(EM),
         .CNT_WIDTH  (CW)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .unsync_bus  (bus_in[g][BW-1:0]),
         .bus_enable  (en[g]),
         .sync_bus    (so),
         .enable_pulse(pulse_o[g]),
         .xfer_count  (co)
      );
      assign sync_o[g] = 32'(so);
      assign cnt_o[g]  = 8'(co);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model state
   logic        hen       [NI][MAXC];
   int          rst_edge  [NI];
   logic [31:0] exp_bus   [NI];
   logic        exp_pulse [NI];
   int          exp_cnt   [NI];
   logic        prev_p    [NI];
   logic [31:0] sbq       [NI][$];
   int          cyc = 0;

   function automatic logic en_at(input int i, input int idx);
      if (idx < 0 || idx <= rst_edge[i]) return 1'b0;
      return hen[i][idx];
   endfunction

   // Model update at each edge, then compare all instances just after it.
   always @(posedge clk) begin
      logic a, b, ev;
      if (cyc >= MAXC - 1) begin
         $display("FAIL cycle_budget actual=%0d required<%0d", cyc, MAXC);
         $fatal(1);
      end
      for (int i = 0; i < NI; i++) begin
         if (!rst) begin
            rst_edge[i]  = cyc;
            hen[i][cyc]  = 1'b0;
            exp_bus[i]   = '0;
            exp_pulse[i] = 1'b0;
            exp_cnt[i]   = 0;
         end else begin
            hen[i][cyc] = en[i];
            a  = en_at(i, cyc - ns_of(i));
            b  = en_at(i, cyc - ns_of(i) - 1);
            ev = (em_of(i) != 0) ? (a ^ b) : (a & ~b);
            exp_pulse[i] = ev;
            if (ev) begin
               exp_bus[i] = bus_in[i] & mask_of(i);
               exp_cnt[i] = (exp_cnt[i] + 1) % (1 << cw_of(i));
            end
         end
      end
      cyc++;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("model_pulse[%0d]", i), 32'(pulse_o[i]), 32'(exp_pulse[i]));
         chk($sformatf("model_bus[%0d]", i), sync_o[i], exp_bus[i]);
         chk($sformatf("model_cnt[%0d]", i), 32'(cnt_o[i]), 32'(exp_cnt[i]));
         if (em_of(i) == 0 && pulse_o[i])
            chk($sformatf("level_single[%0d]", i), 32'(prev_p[i]), 32'd0);
         if (i >= 4 && pulse_o[i]) begin
            checks++;
            if (sbq[i].size() == 0) begin
               errors++;
               $display("FAIL sb_spurious[%0d] actual=pulse required=no_pulse", i);
            end else begin
               logic [31:0] d;
               d = sbq[i].pop_front();
               if (sync_o[i] !== d) begin
                  errors++;
                  $display("FAIL sb_data[%0d] actual=%0h required=%0h", i, sync_o[i], d);
               end
            end
         end
         prev_p[i] = pulse_o[i];
      end
   end

   // Drive one event and check the pulse lands exactly N edges after sampling.
   task automatic xfer(input int i, input logic [31:0] data, input logic ev_val,
                       input int ecnt);
      int n;
      n = ns_of(i);
      @(negedge clk);
      bus_in[i] = data;
      en[i]     = ev_val;
      for (int j = 0; j <= n + 1; j++) begin
         @(posedge clk); #1;
         chk($sformatf("xfer_pulse[%0d] j=%0d", i, j), 32'(pulse_o[i]), (j == n) ? 32'd1 : 32'd0);
         if (j == n) begin
            chk($sformatf("xfer_bus[%0d]", i), sync_o[i], data);
            chk($sformatf("xfer_cnt[%0d]", i), 32'(cnt_o[i]), 32'(ecnt));
         end
      end
   endtask

   task automatic lower(input int i, input int k);
      @(negedge clk);
      en[i] = 1'b0;
      repeat (k) @(negedge clk);
   endtask

   // Protocol-respecting random events: data set one clk ahead and held.
   task automatic rnd(input int i, input int nev);
      int n, hi, lo, lomin;
      logic [31:0] d;
      n = ns_of(i);
      for (int e = 0; e < nev; e++) begin
         @(negedge clk);
         d = $urandom & mask_of(i);
         bus_in[i] = d;
         @(negedge clk);
         sbq[i].push_back(d);
         en[i] = (em_of(i) != 0) ? ~en[i] : 1'b1;
         hi = $urandom_range(n + 2, 1);
         repeat (hi) @(negedge clk);
         if (em_of(i) == 0) en[i] = 1'b0;
         lomin = (n + 2 > hi) ? (n + 2 - hi) : 1;
         lo = $urandom_range(n + 4, lomin);
         repeat (lo) @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] bdat [3];
      int          wrap_exp [5];
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         en[i] = 1'b0; bus_in[i] = '0; rst_edge[i] = -1; prev_p[i] = 1'b0;
      end
      bdat = '{32'h11, 32'h22, 32'h33};
      wrap_exp = '{1, 2, 3, 0, 1};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_bus", sync_o[0], 32'h0);
      chk("reset_pulse", 32'(pulse_o[0]), 32'd0);
      chk("reset_cnt", 32'(cnt_o[3]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Level mode, two stages, enable held high: exactly one pulse.
      xfer(0, 32'hA5, 1'b1, 1);
      for (int j = 0; j < 18; j++) begin
         @(posedge clk); #1;
         chk("held_no_second_pulse", 32'(pulse_o[0]), 32'd0);
      end
      chk("held_cnt", 32'(cnt_o[0]), 32'd1);
      chk("held_bus", sync_o[0], 32'hA5);
      lower(0, 4);

      // Level mode, four stages, three transfers in order.
      for (int k = 0; k < 3; k++) begin
         xfer(1, bdat[k], 1'b1, k + 1);
         lower(1, 2);
      end
      chk("three_cnt", 32'(cnt_o[1]), 32'd3);

      // Toggle mode, three stages, 0->1->0.
      xfer(2, 32'h0F, 1'b1, 1);
      repeat (2) @(negedge clk);
      xfer(2, 32'hF0, 1'b0, 2);
      chk("toggle_final_bus", sync_o[2], 32'hF0);

      // Two-bit counter wraps after three transfers.
      for (int k = 0; k < 5; k++) begin
         xfer(3, 32'(8'h40 + k), 1'b1, wrap_exp[k]);
         lower(3, 3);
      end

      // Reset one cycle after a rise, before the pulse; release with enable high.
      @(negedge clk);
      bus_in[0] = 32'h3C;
      en[0]     = 1'b1;
      @(posedge clk); #1;
      chk("mid_pre_pulse", 32'(pulse_o[0]), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_bus", sync_o[0], 32'h0);
      chk("mid_rst_pulse", 32'(pulse_o[0]), 32'd0);
      chk("mid_rst_cnt0", 32'(cnt_o[0]), 32'd0);
      chk("mid_rst_cnt1", 32'(cnt_o[1]), 32'd0);
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         chk("in_rst_no_pulse", 32'(pulse_o[0]), 32'd0);
      end
      @(negedge clk);
      bus_in[0] = 32'h5A;
      rst = 1'b1;
      for (int j = 0; j <= 3; j++) begin
         @(posedge clk); #1;
         chk($sformatf("release_pulse j=%0d", j), 32'(pulse_o[0]), (j == 2) ? 32'd1 : 32'd0);
         if (j == 2) begin
            chk("release_bus", sync_o[0], 32'h5A);
            chk("release_cnt", 32'(cnt_o[0]), 32'd1);
         end
      end
      lower(0, 4);

      // Random spacing across widths and modes with scoreboard.
      fork
         rnd(4, 40);
         rnd(5, 40);
         rnd(6, 40);
      join
      repeat (15) @(posedge clk);
      #1;
      for (int i = 4; i < NI; i++)
         chk($sformatf("sb_pending[%0d]", i), 32'(sbq[i].size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
